mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 26 ++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 104 ++++++++++
 tb/tb_mem_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the latency-emulating memory responder.
// States are plain encoded constants so older tools can consume them.
package mem_resp_pkg;

   localparam int LATENCY_DEF     = 2;
   localparam int DEPTH_WORDS_DEF = 1024;

   // Value returned by a read that falls outside the storage array.
   localparam logic [31:0] OOR_RD_DATA = 32'h0;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   typedef struct packed {
      logic [29:0] idx;
      logic        wr;
      logic [31:0] data;
   } req_t;

   function automatic logic out_of_range(input logic [29:0] idx, input int aw);
      return |(idx >> aw);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module mem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory slave that completes each access a fixed number of cycles after
// the request is sampled, restarting the wait whenever the request changes.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int LATENCY     = LATENCY_DEF,
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic        mem_wr,
   output logic [31:0] data_out,
   output logic        mem_ready,
   output logic        mem_err
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t      state;
   logic [3:0]  cnt;
   req_t        lat;
   req_t        cur;
   logic        changed;
   logic        go_done;
   logic        we;
   logic        lat_oor;
   logic [31:0] rd_data;
   logic        unused_bits;

   assign cur.idx     = addr[31:2];
   assign cur.wr      = mem_wr;
   assign cur.data    = data_in;
   assign unused_bits = ^addr[1:0];

   // Write data only matters for a write; a read with new data is not a new request.
   assign changed = (cur.idx != lat.idx) || (cur.wr != lat.wr) ||
                    (cur.wr && (cur.data != lat.data));

   always_comb begin
      go_done = 1'b0;
      case (state)
         ST_IDLE: go_done = (LATENCY == 1);
         ST_BUSY: go_done = !changed && (cnt == 4'd1);
         default: go_done = 1'b0;
      endcase
   end

   // On the DONE-entering edge the live inputs equal the latches in every field
   // that matters, so the commit can use them directly in both source states.
   assign we      = go_done && !rst && cur.wr && !out_of_range(cur.idx, AW);
   assign lat_oor = out_of_range(lat.idx, AW);

   mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk     (clk),
      .we      (we),
      .wr_addr (cur.idx[AW-1:0]),
      .wr_data (cur.data),
      .rd_addr (lat.idx[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat       <= '0;
         data_out  <= 32'h0;
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               lat   <= cur;
               cnt   <= CNT_LOAD;
               state <= go_done ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
               if (changed) begin
                  lat <= cur;
                  cnt <= CNT_LOAD;
               end else if (go_done) begin
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_DONE: begin
               mem_ready <= 1'b1;
               mem_err   <= lat_oor;
               data_out  <= lat.wr ? lat.data : (lat_oor ? OOR_RD_DATA : rd_data);
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances at LATENCY 1, 2 and 3,
// a vector table of complete accesses plus hand sequences for abort and reset.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr    [3];
   logic [31:0] data_in [3];
   logic        mem_wr  [3];
   logic [31:0] dout    [3];
   logic        rdy     [3];
   logic        err     [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_responder #(.LATENCY(g + 1), .DEPTH_WORDS(1024)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .addr      (addr[g]),
         .data_in   (data_in[g]),
         .mem_wr    (mem_wr[g]),
         .data_out  (dout[g]),
         .mem_ready (rdy[g]),
         .mem_err   (err[g])
      );
   end

   typedef struct {
      int          d;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   vec_t vt [19];

   function automatic vec_t mk(input int d, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] exp_d,
                               input logic exp_e);
      vec_t v;
      v.d = d; v.wr = wr; v.a = a; v.wd = wd; v.exp_d = exp_d; v.exp_e = exp_e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Precondition: the next rising edge is a sampling edge for instance d.
   task automatic access(input int d, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_d,
                         input logic exp_e, input string tag);
      int n;
      addr[d] = a; data_in[d] = wd; mem_wr[d] = wr;
      @(posedge clk); #1;
      chk({tag, " ready low at sample"}, 32'(rdy[d]), 32'd0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!rdy[d] && n < 20);
      chk({tag, " latency"}, 32'(n), 32'(d + 1));
      chk({tag, " data"}, dout[d], exp_d);
      chk({tag, " err"}, 32'(err[d]), 32'(exp_e));
   endtask

   // Sample one request, change it a cycle later, expect completion of the
   // second one only, counted from the relatch edge.
   task automatic abort_seq(input int d, input logic wr, input logic [31:0] a0,
                            input logic [31:0] d0, input logic [31:0] a1,
                            input logic [31:0] d1, input logic [31:0] exp_d,
                            input string tag);
      int n;
      addr[d] = a0; data_in[d] = d0; mem_wr[d] = wr;
      @(posedge clk); #1;
      addr[d] = a1; data_in[d] = d1;
      @(posedge clk); #1;
      chk({tag, " ready low at relatch"}, 32'(rdy[d]), 32'd0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!rdy[d] && n < 20);
      chk({tag, " latency from relatch"}, 32'(n), 32'(d + 1));
      chk({tag, " data"}, dout[d], exp_d);
      chk({tag, " err"}, 32'(err[d]), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         addr[i] = 32'h0; data_in[i] = 32'h0; mem_wr[i] = 1'b0;
      end

      vt[0]  = mk(1, 1'b1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      vt[1]  = mk(1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      vt[2]  = mk(1, 1'b1, 32'h0,   32'h11111111, 32'h11111111, 1'b0);
      vt[3]  = mk(1, 1'b1, 32'h1000,32'h1234,     32'h1234,     1'b1);
      vt[4]  = mk(1, 1'b0, 32'h0,   32'h0,        32'h11111111, 1'b0);
      vt[5]  = mk(1, 1'b0, 32'h1000,32'h0,        32'h0,        1'b1);
      vt[6]  = mk(1, 1'b1, 32'h40,  32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0);
      vt[7]  = mk(1, 1'b0, 32'h40,  32'h0,        32'h5A5A5A5A, 1'b0);
      vt[8]  = mk(1, 1'b0, 32'h13,  32'h0,        32'hDEADBEEF, 1'b0);
      vt[9]  = mk(1, 1'b1, 32'hFFC, 32'h0BADF00D, 32'h0BADF00D, 1'b0);
      vt[10] = mk(1, 1'b0, 32'hFFC, 32'h0,        32'h0BADF00D, 1'b0);
      vt[11] = mk(1, 1'b1, 32'h8,   32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
      vt[12] = mk(0, 1'b1, 32'h0,   32'h1,        32'h1,        1'b0);
      vt[13] = mk(0, 1'b1, 32'h4,   32'h2,        32'h2,        1'b0);
      vt[14] = mk(0, 1'b0, 32'h0,   32'h0,        32'h1,        1'b0);
      vt[15] = mk(0, 1'b0, 32'h4,   32'h0,        32'h2,        1'b0);
      vt[16] = mk(0, 1'b0, 32'h0,   32'h0,        32'h1,        1'b0);
      vt[17] = mk(2, 1'b1, 32'h24,  32'h99990009, 32'h99990009, 1'b0);
      vt[18] = mk(2, 1'b1, 32'h20,  32'h20202020, 32'h20202020, 1'b0);

      do_reset();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset ready d%0d", i), 32'(rdy[i]), 32'd0);
         chk($sformatf("reset err d%0d", i),   32'(err[i]), 32'd0);
         chk($sformatf("reset data d%0d", i),  dout[i],     32'h0);
      end

      for (int i = 0; i < 19; i++) begin
         if (i > 0 && vt[i].d != vt[i-1].d) do_reset();
         access(vt[i].d, vt[i].wr, vt[i].a, vt[i].wd, vt[i].exp_d, vt[i].exp_e,
                $sformatf("vec%0d", i));
      end

      // LATENCY=3: address change mid-wait restarts the count.
      abort_seq(2, 1'b0, 32'h20, 32'h0, 32'h24, 32'h0, 32'h99990009, "abort addr");
      // Write data change mid-wait: only the second value lands.
      abort_seq(2, 1'b1, 32'h30, 32'h1, 32'h30, 32'h2, 32'h2, "abort wdata");
      access(2, 1'b0, 32'h30, 32'h0, 32'h2, 1'b0, "read after abort");

      // Reset during the wait of a write must drop it.
      do_reset();
      access(1, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, "pre-reset read");
      addr[1] = 32'h8; data_in[1] = 32'hAAAA5555; mem_wr[1] = 1'b1;
      @(posedge clk); #1;
      chk("busy holds data", dout[1], 32'hCAFEF00D);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst mid-busy ready", 32'(rdy[1]), 32'd0);
      chk("rst mid-busy err",   32'(err[1]), 32'd0);
      chk("rst mid-busy data",  dout[1],     32'h0);
      rst = 1'b0;
      access(1, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, "post-reset read");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
